// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus bundle between the CPU (master) and the UART transmitter (slave).
interface uart_tx_mmio_if;
  logic [3:0]  READ;
  logic [2:0]  WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITEDATA;
  logic [31:0] READDATA;
  logic        BUSYWAIT;
  logic        HIT;

  modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT, HIT);
  modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT, HIT);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser on TX.
// Optional feature macro: UART_TX_PARITY_EN adds a switchable even-parity bit.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_mmio_if.slave bus,
  output logic          TX,
  output logic          TX_ACTIVE
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic          ack_q;
  logic [15:0]   div_q, cur_div, baud;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic [2:0]    state, bitcnt;
  logic [7:0]    shreg;
  logic          par_q, par_en;
  logic [31:0]   rword, rdata;

  wire       wr_en = bus.WRITE[2];
  wire       rd_en = bus.READ[3] & ~wr_en;
  wire [1:0] off   = bus.ADDRESS[3:2];

  assign bus.HIT      = (bus.ADDRESS[31:4] == BASE_ADDR[31:4]) & (bus.READ[3] | wr_en);
  assign bus.BUSYWAIT = bus.HIT & ~ack_q;
  assign TX_ACTIVE    = (state != S_IDLE);

  wire fifo_full  = (cnt == (AW+1)'(FIFO_DEPTH));
  wire fifo_empty = (cnt == '0);
  wire baud_end   = (baud == 16'd0);
  wire pop        = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & baud_end));

  // A TXDATA store into a full FIFO waits; it can land on the same edge a pop frees a slot.
  wire push_req = bus.HIT & wr_en & (off == 2'd0);
  wire complete = bus.HIT & ~ack_q & ~(push_req & fifo_full & ~pop);
  wire push     = complete & push_req;
  wire [15:0] div_wr = (bus.WRITEDATA[15:0] == 16'd0) ? 16'd1 : bus.WRITEDATA[15:0];

  always_comb begin
    rword = '0;
    case (off)
      2'd1:    rword = {27'b0, par_en, fifo_full, fifo_empty, TX_ACTIVE, 1'b0};
      2'd2:    rword = {16'b0, div_q};
      default: rword = '0;
    endcase
    case (bus.READ[2:0])
      3'b000:  rdata = {{24{rword[7]}}, rword[7:0]};
      3'b001:  rdata = {{16{rword[15]}}, rword[15:0]};
      3'b100:  rdata = {24'b0, rword[7:0]};
      3'b101:  rdata = {16'b0, rword[15:0]};
      default: rdata = rword;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ack_q        <= 1'b0;
      bus.READDATA <= '0;
      div_q        <= DEFAULT_DIV;
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
    end else begin
      ack_q <= complete;
      if (complete & rd_en) bus.READDATA <= rdata;
      if (complete & wr_en & (off == 2'd2)) div_q <= div_wr;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= bus.WRITEDATA[7:0];
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge CLK) begin
    if (!RST) par_en <= 1'b1;
    else if (complete & wr_en & (off == 2'd1)) par_en <= bus.WRITEDATA[4];
  end
  logic unused_bits;
  assign unused_bits = ^{bus.WRITEDATA[31:16], bus.WRITE[1:0], bus.ADDRESS[1:0]};
`else
  assign par_en = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{bus.WRITEDATA[31:16], bus.WRITE[1:0], bus.ADDRESS[1:0], par_q};
`endif

  // A pop always starts a frame, whether from IDLE or straight out of STOP.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= S_IDLE;
      TX      <= 1'b1;
      bitcnt  <= '0;
      baud    <= '0;
      cur_div <= DEFAULT_DIV;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else if (pop) begin
      state   <= S_START;
      TX      <= 1'b0;
      shreg   <= mem[rptr];
      par_q   <= ^mem[rptr];
      cur_div <= div_q;
      baud    <= div_q - 16'd1;
    end else begin
      case (state)
        S_START: if (baud_end) begin
          state  <= S_DATA;
          TX     <= shreg[0];
          bitcnt <= '0;
          baud   <= cur_div - 16'd1;
        end else baud <= baud - 16'd1;
        S_DATA: if (baud_end) begin
          baud <= cur_div - 16'd1;
          if (bitcnt == 3'd7) begin
            state <= par_en ? S_PARITY : S_STOP;
            TX    <= par_en ? par_q : 1'b1;
          end else begin
            bitcnt <= bitcnt + 3'd1;
            shreg  <= shreg >> 1;
            TX     <= shreg[1];
          end
        end else baud <= baud - 16'd1;
        S_PARITY: if (baud_end) begin
          state <= S_STOP;
          TX    <= 1'b1;
          baud  <= cur_div - 16'd1;
        end else baud <= baud - 16'd1;
        S_STOP: if (baud_end) state <= S_IDLE;
                else baud <= baud - 16'd1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, stall timing and serial framing.
module tb_uart_tx_mmio;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic TX, TX_ACTIVE;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q [$];

`ifdef UART_TX_PARITY_EN
  localparam int          NBITS     = 11;
  localparam logic [31:0] STAT_IDLE = 32'h14;
`else
  localparam int          NBITS     = 10;
  localparam logic [31:0] STAT_IDLE = 32'h04;
`endif
  localparam logic [31:0] A_TXD = 32'hFFFF_0000;
  localparam logic [31:0] A_STA = 32'hFFFF_0004;
  localparam logic [31:0] A_DIV = 32'hFFFF_0008;
  localparam logic [31:0] A_RSV = 32'hFFFF_000C;
  localparam logic [3:0]  LW = 4'b1010, LB = 4'b1000, LH = 4'b1001, LBU = 4'b1100, RNONE = 4'b0000;
  localparam logic [2:0]  SB = 3'b100, SW = 3'b110, WNONE = 3'b000;

  uart_tx_mmio_if bif();

  uart_tx_mmio #(.BASE_ADDR(32'hFFFF_0000), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd868)) dut (
    .CLK(CLK), .RST(RST), .bus(bif.slave), .TX(TX), .TX_ACTIVE(TX_ACTIVE)
  );

  always #5 CLK = ~CLK;

  // Called at posedge+1; returns at posedge+1 after the ack cycle.
  task automatic bus(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rdat, output int stalls);
    bif.READ = rd; bif.WRITE = wr; bif.ADDRESS = addr; bif.WRITEDATA = wd;
    stalls = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (!bif.BUSYWAIT) break;
      stalls++;
      @(posedge CLK); #1;
    end
    if (stalls >= 5000) begin
      checks++; errors++;
      $display("FAIL bus_timeout addr=%h: still stalled after %0d cycles, required completion", addr, stalls);
    end
    rdat = bif.READDATA;
    @(posedge CLK); #1;
    bif.READ = RNONE; bif.WRITE = WNONE;
  endtask

  task automatic check_stream(input int nbits, input int div, input string name);
    int bad, first_bad, tot, f, b;
    logic e, found;
    logic [7:0] by;
    bad = 0; first_bad = -1; found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge CLK);
      if (TX === 1'b0) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_start: TX=%b, required start bit 0", name, TX);
      return;
    end
    tot = exp_q.size() * nbits * div;
    for (int c = 0; c < tot; c++) begin
      if (c > 0) @(negedge CLK);
      f = c / (nbits * div);
      b = (c % (nbits * div)) / div;
      by = exp_q[f];
      if (b == 0) e = 1'b0;
      else if (b <= 8) e = by[b-1];
      else if (b == 9 && nbits == 11) e = ^by;
      else e = 1'b1;
      if (TX !== e) begin
        bad++;
        if (first_bad < 0) first_bad = c;
      end
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_bits: %0d wrong samples (first at clock %0d), required 0", name, bad, first_bad);
    end
    @(negedge CLK);
    checks++;
    if (TX_ACTIVE !== 1'b0 || TX !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle: TX_ACTIVE=%b TX=%b after last stop bit, required 0/1", name, TX_ACTIVE, TX);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r; int s;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", TX); end
    checks++; if (TX_ACTIVE !== 1'b0) begin errors++; $display("FAIL rst_active: got %b want 0", TX_ACTIVE); end
    checks++; if (bif.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL rst_busywait: got %b want 0", bif.BUSYWAIT); end
    checks++; if (bif.READDATA !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h want 0", bif.READDATA); end
    bus(LW, WNONE, A_STA, 32'h0, r, s);
    checks++; if (r !== STAT_IDLE) begin errors++; $display("FAIL rst_status: got %h want %h", r, STAT_IDLE); end
    bus(LW, WNONE, A_DIV, 32'h0, r, s);
    checks++; if (r !== 32'h364) begin errors++; $display("FAIL rst_div: got %h want 00000364", r); end
  endtask

  task automatic test_single_frame();
    logic [31:0] r; int s;
    bus(RNONE, SW, A_DIV, 32'd4, r, s);
    exp_q = '{8'h55};
    fork
      begin
        bus(RNONE, SB, A_TXD, 32'h0000_0055, r, s);
        checks++; if (s !== 1) begin errors++; $display("FAIL single_stall: got %0d want 1", s); end
      end
      check_stream(NBITS, 4, "single");
    join
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int st [6];
    exp_q = '{8'hA1, 8'h5C, 8'h0F, 8'hF0, 8'h3B, 8'h96};
    fork
      begin
        for (int k = 0; k < 6; k++) bus(RNONE, SB, A_TXD, {24'h0, exp_q[k]}, r, st[k]);
      end
      check_stream(NBITS, 4, "b2b");
    join
    // First byte goes straight to the shifter, so the sixth store is the one that meets a full FIFO.
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (st[k] !== 1) begin errors++; $display("FAIL b2b_stall%0d: got %0d want 1", k, st[k]); end
    end
    checks++;
    if (st[5] !== NBITS*4 - 8) begin errors++; $display("FAIL b2b_full_stall: got %0d want %0d", st[5], NBITS*4 - 8); end
  endtask

  task automatic test_non_hit();
    logic [31:0] r; int s;
    bus(LW, WNONE, A_DIV, 32'h0, r, s);
    checks++; if (r !== 32'd4) begin errors++; $display("FAIL nohit_pre: got %h want 00000004", r); end
    bif.READ = LW; bif.WRITE = WNONE; bif.ADDRESS = 32'h0001_0000;
    @(negedge CLK);
    checks++; if (bif.HIT !== 1'b0) begin errors++; $display("FAIL nohit_hit: got %b want 0", bif.HIT); end
    checks++; if (bif.BUSYWAIT !== 1'b0) begin errors++; $display("FAIL nohit_busy: got %b want 0", bif.BUSYWAIT); end
    @(posedge CLK); #1;
    checks++; if (bif.READDATA !== 32'd4) begin errors++; $display("FAIL nohit_rdata: got %h want 00000004", bif.READDATA); end
    bif.READ = RNONE;
  endtask

  task automatic test_regs();
    logic [31:0] r; int s;
    bus(RNONE, SW, A_DIV, 32'h0000_0080, r, s);
    bus(LB, WNONE, A_DIV, 32'h0, r, s);
    checks++; if (r !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_div: got %h want ffffff80", r); end
    bus(LBU, WNONE, A_DIV, 32'h0, r, s);
    checks++; if (r !== 32'h0000_0080) begin errors++; $display("FAIL lbu_div: got %h want 00000080", r); end
    bus(LH, WNONE, A_DIV, 32'h0, r, s);
    checks++; if (r !== 32'h0000_0080) begin errors++; $display("FAIL lh_div: got %h want 00000080", r); end
    bus(RNONE, SW, A_DIV, 32'h0, r, s);
    bus(LW, WNONE, A_DIV, 32'h0, r, s);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL div_zero: got %h want 00000001", r); end
    bus(RNONE, SW, A_RSV, 32'hDEAD_BEEF, r, s);
    bus(LW, WNONE, A_RSV, 32'h0, r, s);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reserved: got %h want 0", r); end
    bus(LW, WNONE, A_TXD, 32'h0, r, s);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL txdata_rd: got %h want 0", r); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r; int s; int hi_bad;
    bus(RNONE, SW, A_DIV, 32'd4, r, s);
    bus(RNONE, SB, A_TXD, 32'hC3, r, s);
    bus(RNONE, SB, A_TXD, 32'h11, r, s);
    bus(RNONE, SB, A_TXD, 32'h22, r, s);
    repeat (13) @(posedge CLK);
    #1;
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b want 0", TX); end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b want 1", TX); end
    checks++; if (TX_ACTIVE !== 1'b0) begin errors++; $display("FAIL mid_rst_active: got %b want 0", TX_ACTIVE); end
    RST = 1'b1;
    bus(LW, WNONE, A_STA, 32'h0, r, s);
    checks++; if (r !== STAT_IDLE) begin errors++; $display("FAIL mid_status: got %h want %h", r, STAT_IDLE); end
    hi_bad = 0;
    repeat (200) begin
      @(negedge CLK);
      if (TX !== 1'b1 || TX_ACTIVE !== 1'b0) hi_bad++;
    end
    checks++; if (hi_bad != 0) begin errors++; $display("FAIL mid_no_frames: %0d busy samples, want 0", hi_bad); end
    @(posedge CLK); #1;
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [31:0] r; int s;
    bus(RNONE, SW, A_DIV, 32'd4, r, s);
    exp_q = '{8'h07};
    fork
      bus(RNONE, SB, A_TXD, 32'h07, r, s);
      check_stream(11, 4, "par_on");
    join
    @(posedge CLK); #1;
    bus(RNONE, SW, A_STA, 32'h0, r, s);
    bus(LW, WNONE, A_STA, 32'h0, r, s);
    checks++; if (r !== 32'h04) begin errors++; $display("FAIL par_status: got %h want 00000004", r); end
    fork
      bus(RNONE, SB, A_TXD, 32'h07, r, s);
      check_stream(10, 4, "par_off");
    join
  endtask
`endif

  initial begin
    bif.READ = RNONE; bif.WRITE = WNONE; bif.ADDRESS = '0; bif.WRITEDATA = '0;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    test_reset();
    test_single_frame();
    @(posedge CLK); #1;
    test_back_to_back();
    @(posedge CLK); #1;
    test_non_hit();
    test_regs();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
